// File: rtl/move_bus_regbank.sv
// Register bank responder for the move-FSM transfer protocol: R0-R3, output port P0, input port P1.
// One-hot read strobes select a single bus source; write strobes capture the bus on the rising edge.
module move_bus_regbank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             R0_write,
  input  logic             R1_write,
  input  logic             R2_write,
  input  logic             R3_write,
  input  logic             P0_write,
  input  logic             R0_read,
  input  logic             R1_read,
  input  logic             R2_read,
  input  logic             R3_read,
  input  logic             P0_read,
  input  logic             P1_read,
  input  logic             ext_drive,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [WIDTH-1:0] p1_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] p0_out,
  output logic             p0_strobe,
  output logic             xfer_done,
  output logic             bus_err,
  output logic [WIDTH-1:0] r0_q,
  output logic [WIDTH-1:0] r1_q,
  output logic [WIDTH-1:0] r2_q,
  output logic [WIDTH-1:0] r3_q
);

  logic [6:0]       src_sel;
  logic [2:0]       src_cnt;
  logic             one_src;
  logic             conflict;
  logic             any_write;
  logic [WIDTH-1:0] p1_meta;
  logic [WIDTH-1:0] p1_sync;
  logic [WIDTH-1:0] bus_val;

  assign src_sel   = {ext_drive, P1_read, P0_read, R3_read, R2_read, R1_read, R0_read};
  assign src_cnt   = 3'($countones(src_sel));
  assign one_src   = (src_cnt == 3'd1);
  assign conflict  = (src_cnt > 3'd1);
  assign any_write = R0_write | R1_write | R2_write | R3_write | P0_write;

  // AND-OR mux is only meaningful with exactly one source; otherwise the bus is forced to zero.
  always_comb begin
    bus_val = '0;
    if (one_src) begin
      bus_val = ({WIDTH{R0_read}}   & r0_q)
              | ({WIDTH{R1_read}}   & r1_q)
              | ({WIDTH{R2_read}}   & r2_q)
              | ({WIDTH{R3_read}}   & r3_q)
              | ({WIDTH{P0_read}}   & p0_out)
              | ({WIDTH{P1_read}}   & p1_sync)
              | ({WIDTH{ext_drive}} & ext_data);
    end
  end

  assign bus = bus_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      p0_out    <= '0;
      p1_meta   <= '0;
      p1_sync   <= '0;
      p0_strobe <= 1'b0;
      xfer_done <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      p1_meta <= p1_in;
      p1_sync <= p1_meta;
      if (one_src) begin
        if (R0_write) r0_q   <= bus_val;
        if (R1_write) r1_q   <= bus_val;
        if (R2_write) r2_q   <= bus_val;
        if (R3_write) r3_q   <= bus_val;
        if (P0_write) p0_out <= bus_val;
      end
      xfer_done <= one_src & any_write;
      p0_strobe <= one_src & P0_write;
      // A fresh conflict takes priority over a simultaneous clear.
      if (conflict) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_bus_regbank.sv
// Self-checking bench for move_bus_regbank: directed scenarios plus randomized transfers
// checked against a transfer-level model of the register bank.
module tb_move_bus_regbank;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   rw = '0;
  logic [3:0]   rr = '0;
  logic         p0w = 1'b0, p0r = 1'b0, p1r = 1'b0, ext_drive = 1'b0, err_clr = 1'b0;
  logic [W-1:0] ext_data = '0, p1_in = '0;
  logic [W-1:0] bus, p0_out, r0_q, r1_q, r2_q, r3_q;
  logic         p0_strobe, xfer_done, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_r [4];
  logic [W-1:0] m_p0;
  logic [W-1:0] m_p1_hist [2];  // [0] = sampled last edge, [1] = sampled the edge before
  logic         m_xfer, m_strobe, m_err;

  move_bus_regbank #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .R0_write(rw[0]), .R1_write(rw[1]), .R2_write(rw[2]), .R3_write(rw[3]), .P0_write(p0w),
    .R0_read(rr[0]), .R1_read(rr[1]), .R2_read(rr[2]), .R3_read(rr[3]),
    .P0_read(p0r), .P1_read(p1r), .ext_drive(ext_drive), .ext_data(ext_data),
    .p1_in(p1_in), .err_clr(err_clr), .bus(bus), .p0_out(p0_out), .p0_strobe(p0_strobe),
    .xfer_done(xfer_done), .bus_err(bus_err),
    .r0_q(r0_q), .r1_q(r1_q), .r2_q(r2_q), .r3_q(r3_q)
  );

  always #5 clk = ~clk;

  function automatic int n_src();
    return $countones({rr, p0r, p1r, ext_drive});
  endfunction

  function automatic logic [W-1:0] exp_bus();
    if (n_src() != 1) return '0;
    for (int k = 0; k < 4; k++) if (rr[k]) return m_r[k];
    if (p0r) return m_p0;
    if (p1r) return m_p1_hist[1];
    return ext_data;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_r[k] = '0;
    m_p0 = '0; m_p1_hist[0] = '0; m_p1_hist[1] = '0;
    m_xfer = 1'b0; m_strobe = 1'b0; m_err = 1'b0;
  endtask

  task automatic clear_strobes();
    rw = '0; rr = '0; p0w = 0; p0r = 0; p1r = 0; ext_drive = 0; err_clr = 0;
  endtask

  // One rising edge; the model applies the transfer rules for the strobes present at the edge.
  task automatic tick();
    int n;
    logic [W-1:0] bv;
    n = n_src();
    bv = exp_bus();
    @(posedge clk);
    if (n == 1) begin
      for (int k = 0; k < 4; k++) if (rw[k]) m_r[k] = bv;
      if (p0w) m_p0 = bv;
    end
    m_xfer   = (n == 1) && ((rw != 0) || p0w);
    m_strobe = (n == 1) && p0w;
    if (n >= 2) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_p1_hist[1] = m_p1_hist[0];
    m_p1_hist[0] = p1_in;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    clear_strobes();
    reset_n = 1'b0;
    #12;
    reset_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({r0_q, r1_q, r2_q, r3_q, p0_out, bus} !== '0 || {xfer_done, p0_strobe, bus_err} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_idle: r0=%h r1=%h r2=%h r3=%h p0=%h bus=%h xd=%b ps=%b err=%b required all zero",
               r0_q, r1_q, r2_q, r3_q, p0_out, bus, xfer_done, p0_strobe, bus_err);
    end
    $display("reset_idle: r0=%h r1=%h r2=%h r3=%h p0=%h bus=%h", r0_q, r1_q, r2_q, r3_q, p0_out, bus);
  endtask

  task automatic test_ext_write();
    ext_drive = 1; ext_data = 16'h1234; rw[1] = 1;
    #1;
    n_checks++;
    if (bus !== 16'h1234) begin n_errors++; $display("FAIL ext_bus: got %h want 1234", bus); end
    tick();
    clear_strobes();
    n_checks++;
    if (r1_q !== 16'h1234 || xfer_done !== 1'b1) begin
      n_errors++; $display("FAIL ext_write: r1=%h xd=%b want 1234/1", r1_q, xfer_done);
    end
    tick();
    n_checks++;
    if (xfer_done !== 1'b0) begin n_errors++; $display("FAIL ext_ack_pulse: xd=%b want 0", xfer_done); end
    $display("ext_write: r1=%h xfer_done=%b", r1_q, xfer_done);
  endtask

  task automatic test_p0_path();
    rr[1] = 1; p0w = 1;
    tick();
    clear_strobes();
    n_checks++;
    if (p0_out !== 16'h1234 || p0_strobe !== 1'b1) begin
      n_errors++; $display("FAIL p0_write: p0=%h ps=%b want 1234/1", p0_out, p0_strobe);
    end
    tick();
    n_checks++;
    if (p0_strobe !== 1'b0) begin n_errors++; $display("FAIL p0_strobe_pulse: ps=%b want 0", p0_strobe); end
    p0r = 1; rw[3] = 1;
    tick();
    clear_strobes();
    n_checks++;
    if (r3_q !== 16'h1234 || p0_strobe !== 1'b0) begin
      n_errors++; $display("FAIL p0_read: r3=%h ps=%b want 1234/0", r3_q, p0_strobe);
    end
    $display("p0_path: p0_out=%h r3=%h", p0_out, r3_q);
  endtask

  task automatic test_p1_broadcast();
    p1_in = 16'hBEEF;
    tick();
    p1r = 1;
    #1;
    n_checks++;
    if (bus !== 16'h0000) begin n_errors++; $display("FAIL p1_sync_latency: bus=%h want 0000", bus); end
    p1r = 0;
    tick();
    p1r = 1; rw[0] = 1; rw[2] = 1;
    #1;
    n_checks++;
    if (bus !== 16'hBEEF) begin n_errors++; $display("FAIL p1_bus: bus=%h want beef", bus); end
    tick();
    clear_strobes();
    n_checks++;
    if (r0_q !== 16'hBEEF || r2_q !== 16'hBEEF || r1_q !== 16'h1234) begin
      n_errors++; $display("FAIL p1_broadcast: r0=%h r2=%h r1=%h want beef/beef/1234", r0_q, r2_q, r1_q);
    end
    $display("p1_broadcast: r0=%h r2=%h", r0_q, r2_q);
  endtask

  task automatic test_conflict();
    rr[0] = 1; rr[1] = 1; rw[3] = 1;
    #1;
    n_checks++;
    if (bus !== 16'h0000) begin n_errors++; $display("FAIL conflict_bus: bus=%h want 0000", bus); end
    tick();
    clear_strobes();
    n_checks++;
    if (r3_q !== 16'h1234 || bus_err !== 1'b1 || xfer_done !== 1'b0) begin
      n_errors++; $display("FAIL conflict: r3=%h err=%b xd=%b want 1234/1/0", r3_q, bus_err, xfer_done);
    end
    tick();
    n_checks++;
    if (bus_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: err=%b want 1", bus_err); end
    err_clr = 1; rr[2] = 1; ext_drive = 1;
    tick();
    clear_strobes();
    n_checks++;
    if (bus_err !== 1'b1) begin n_errors++; $display("FAIL err_set_wins: err=%b want 1", bus_err); end
    err_clr = 1;
    tick();
    clear_strobes();
    n_checks++;
    if (bus_err !== 1'b0) begin n_errors++; $display("FAIL err_clr: err=%b want 0", bus_err); end
    rw[1] = 1;
    tick();
    clear_strobes();
    n_checks++;
    if (r1_q !== 16'h1234 || xfer_done !== 1'b0 || bus_err !== 1'b0) begin
      n_errors++; $display("FAIL no_source_write: r1=%h xd=%b err=%b want 1234/0/0", r1_q, xfer_done, bus_err);
    end
    $display("conflict: r3=%h bus_err=%b", r3_q, bus_err);
  endtask

  task automatic test_back_to_back();
    ext_drive = 1; ext_data = 16'h00A5; rw[2] = 1; p0w = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ext_data = ext_data + 16'h0101;
      n_checks++;
      if (xfer_done !== 1'b1 || p0_strobe !== 1'b1 || r2_q !== m_r[2]) begin
        n_errors++; $display("FAIL held_strobes[%0d]: xd=%b ps=%b r2=%h want 1/1/%h", i, xfer_done, p0_strobe, r2_q, m_r[2]);
      end
    end
    clear_strobes();
    rr[2] = 1; rw[2] = 1;
    tick();
    clear_strobes();
    n_checks++;
    if (r2_q !== 16'h02A7 || xfer_done !== 1'b1) begin
      n_errors++; $display("FAIL self_move: r2=%h xd=%b want 02a7/1", r2_q, xfer_done);
    end
    $display("back_to_back: r2=%h p0=%h", r2_q, p0_out);
  endtask

  task automatic test_random();
    logic [W-1:0] eb;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) begin
        rr[k] = ($urandom_range(0, 5) == 0);
        rw[k] = ($urandom_range(0, 2) == 0);
      end
      p0r = ($urandom_range(0, 5) == 0);
      p1r = ($urandom_range(0, 5) == 0);
      ext_drive = ($urandom_range(0, 3) == 0);
      p0w = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      ext_data = W'($urandom);
      if ($urandom_range(0, 3) == 0) p1_in = W'($urandom);
      #1;
      eb = exp_bus();
      n_checks++;
      if (bus !== eb) begin n_errors++; $display("FAIL rand_bus[%0d]: got %h want %h", i, bus, eb); end
      tick();
      n_checks++;
      if (r0_q !== m_r[0] || r1_q !== m_r[1] || r2_q !== m_r[2] || r3_q !== m_r[3] || p0_out !== m_p0 ||
          xfer_done !== m_xfer || p0_strobe !== m_strobe || bus_err !== m_err) begin
        n_errors++;
        $display("FAIL rand_state[%0d]: got r=%h/%h/%h/%h p0=%h xd=%b ps=%b err=%b want %h/%h/%h/%h p0=%h xd=%b ps=%b err=%b",
                 i, r0_q, r1_q, r2_q, r3_q, p0_out, xfer_done, p0_strobe, bus_err,
                 m_r[0], m_r[1], m_r[2], m_r[3], m_p0, m_xfer, m_strobe, m_err);
      end
    end
    clear_strobes();
    $display("random: %0d transfers, r0=%h r1=%h r2=%h r3=%h p0=%h", 300, r0_q, r1_q, r2_q, r3_q, p0_out);
  endtask

  task automatic test_reset_mid();
    ext_drive = 1; ext_data = 16'h5A5A; rw = 4'hF; p0w = 1; rr[0] = 1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({r0_q, r1_q, r2_q, r3_q, p0_out} !== '0 || {xfer_done, p0_strobe, bus_err} !== 3'b000) begin
      n_errors++; $display("FAIL reset_async: r0=%h r1=%h r2=%h r3=%h p0=%h xd=%b ps=%b err=%b want all zero",
                           r0_q, r1_q, r2_q, r3_q, p0_out, xfer_done, p0_strobe, bus_err);
    end
    rr = '0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({r0_q, r1_q, r2_q, r3_q, p0_out} !== '0 || {xfer_done, p0_strobe, bus_err} !== 3'b000) begin
      n_errors++; $display("FAIL reset_held_strobes: r0=%h r1=%h p0=%h xd=%b ps=%b want zero", r0_q, r1_q, p0_out, xfer_done, p0_strobe);
    end
    clear_strobes();
    p1_in = '0;
    #2;
    reset_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({r0_q, r1_q, r2_q, r3_q, p0_out, bus} !== '0 || {xfer_done, p0_strobe, bus_err} !== 3'b000) begin
      n_errors++; $display("FAIL reset_release: r0=%h r1=%h r2=%h r3=%h p0=%h bus=%h want all zero",
                           r0_q, r1_q, r2_q, r3_q, p0_out, bus);
    end
    $display("reset_mid: r0=%h p0=%h xfer_done=%b", r0_q, p0_out, xfer_done);
  endtask

  initial begin
    test_reset();
    test_ext_write();
    test_p0_path();
    test_p1_broadcast();
    test_conflict();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
